// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the CPU and a DMA requester,
// sequencing each access as issue, latency wait, data capture and a one-cycle ack.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 3
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic          owner_o
);
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [SW-1:0] starve_q;
    logic          owner_q, we_q, mem_en_q, cpu_ack_q, dma_ack_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, cpu_rdata_q, dma_rdata_q;
    logic          dma_win;
    logic          starved;

    // DMA wins when alone, or when it has lost STARVE_LIM arbitrations in a row
    assign starved = starve_q == SW'(STARVE_LIM);
    assign dma_win = dma_req_i & (~cpu_req_i | starved);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            mem_en_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (cpu_req_i | dma_req_i) begin
                    owner_q  <= dma_win;
                    we_q     <= dma_win ? dma_we_i : cpu_we_i;
                    addr_q   <= dma_win ? dma_addr_i : cpu_addr_i;
                    wdata_q  <= dma_win ? dma_wdata_i : cpu_wdata_i;
                    starve_q <= dma_win ? '0 : (dma_req_i && !starved) ? starve_q + 1'b1 : starve_q;
                    mem_en_q <= 1'b1;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= 4'(MEM_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    // capture happens on writes too, so the ack always carries the port's read data
                    if (owner_q) dma_rdata_q <= mem_rdata_i;
                    else         cpu_rdata_q <= mem_rdata_i;
                    cpu_ack_q <= ~owner_q;
                    dma_ack_q <= owner_q;
                    state_q   <= DONE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_ack_o   = dma_ack_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = state_q != IDLE;
    assign owner_o     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against two arbiters (MEM_LAT=1 and MEM_LAT=3),
// each backed by its own small memory model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req [2], cpu_we [2], dma_req [2], dma_we [2];
    logic [15:0] cpu_addr [2], cpu_wdata [2], dma_addr [2], dma_wdata [2];
    logic [15:0] cpu_rdata [2], dma_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        cpu_ack [2], cpu_stall [2], dma_ack [2], mem_en [2], mem_we [2], busy [2], owner [2];
    logic [15:0] mem [2][0:65535];

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_LIM(3)) u1 (
        .clock_i(clk), .reset_n_i(rst_n),
        .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_addr_i(cpu_addr[0]), .cpu_wdata_i(cpu_wdata[0]),
        .cpu_rdata_o(cpu_rdata[0]), .cpu_ack_o(cpu_ack[0]), .cpu_stall_o(cpu_stall[0]),
        .dma_req_i(dma_req[0]), .dma_we_i(dma_we[0]), .dma_addr_i(dma_addr[0]), .dma_wdata_i(dma_wdata[0]),
        .dma_rdata_o(dma_rdata[0]), .dma_ack_o(dma_ack[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0]), .owner_o(owner[0])
    );

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_LIM(3)) u3 (
        .clock_i(clk), .reset_n_i(rst_n),
        .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_addr_i(cpu_addr[1]), .cpu_wdata_i(cpu_wdata[1]),
        .cpu_rdata_o(cpu_rdata[1]), .cpu_ack_o(cpu_ack[1]), .cpu_stall_o(cpu_stall[1]),
        .dma_req_i(dma_req[1]), .dma_we_i(dma_we[1]), .dma_addr_i(dma_addr[1]), .dma_wdata_i(dma_wdata[1]),
        .dma_rdata_o(dma_rdata[1]), .dma_ack_o(dma_ack[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1]), .owner_o(owner[1])
    );

    // read data appears the cycle after the issue and holds until the next issue
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i]) begin
                mem_rdata[i] <= mem[i][mem_addr[i]];
                if (mem_we[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
            end
        end
    end

    int pass_n = 0;
    int tot_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        int          d;
        logic        creq, cwe;
        logic [15:0] caddr, cwd;
        logic        dreq, dwe;
        logic [15:0] daddr, dwd;
        logic        eown, ewe;
        logic [15:0] eaddr, ewd, erd;
    } vec_t;

    vec_t vt [7];

    task automatic run_vec(input vec_t v, input int drop_t);
        int d, lat, en_t, en_n, ack_t, ack_n, bad_n;
        logic [15:0] ea, ew, rd;
        logic eweq, ow, stall_ack, stall_1;
        d = v.d; lat = d ? 3 : 1;
        en_t = 0; en_n = 0; ack_t = 0; ack_n = 0; bad_n = 0;
        ea = '0; ew = '0; rd = '0; eweq = 1'bx; ow = 1'bx; stall_ack = 1'bx; stall_1 = 1'bx;
        cpu_req[d] = v.creq; cpu_we[d] = v.cwe; cpu_addr[d] = v.caddr; cpu_wdata[d] = v.cwd;
        dma_req[d] = v.dreq; dma_we[d] = v.dwe; dma_addr[d] = v.daddr; dma_wdata[d] = v.dwd;
        for (int t = 1; t <= lat + 6; t++) begin
            @(posedge clk); #1;
            if (t == 1) stall_1 = cpu_stall[d];
            if (mem_en[d]) begin
                en_n++;
                if (en_t == 0) begin en_t = t; ea = mem_addr[d]; ew = mem_wdata[d]; eweq = mem_we[d]; end
            end
            if (v.eown ? dma_ack[d] : cpu_ack[d]) begin
                ack_n++;
                if (ack_t == 0) begin
                    ack_t = t; rd = v.eown ? dma_rdata[d] : cpu_rdata[d];
                    ow = owner[d]; stall_ack = cpu_stall[d];
                    cpu_req[d] = 1'b0; dma_req[d] = 1'b0;
                end
            end
            if (v.eown ? cpu_ack[d] : dma_ack[d]) bad_n++;
            if (t == drop_t) cpu_req[d] = 1'b0;
        end
        chk("en_cycle", en_t, 1);
        chk("en_pulses", en_n, 1);
        chk("mem_addr", ea, v.eaddr);
        chk("mem_wdata", ew, v.ewd);
        chk("mem_we", eweq, v.ewe);
        chk("ack_cycle", ack_t, lat + 2);
        chk("ack_pulses", ack_n, 1);
        chk("other_ack", bad_n, 0);
        chk("rdata", rd, v.erd);
        chk("owner", ow, v.eown);
        chk("stall_at_ack", stall_ack, 0);
        chk("stall_first", stall_1, v.creq);
        chk("busy_after", busy[d], 0);
    endtask

    initial begin
        int ack_a [8];
        int own_a [8];
        int n, t1, t2, en2, a2;
        logic [15:0] addr2, rd2;
        vec_t rv;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
            dma_req[i] = 0; dma_we[i] = 0; dma_addr[i] = 0; dma_wdata[i] = 0;
            mem[i][16'h0040] = 16'hBEEF; mem[i][16'h0042] = 16'h1111; mem[i][16'h0080] = 16'hA5A5;
            mem[i][16'h1000] = 16'h0F0F; mem[i][16'h2000] = 16'h5555;
        end
        //          d  creq cwe caddr     cwd       dreq dwe daddr     dwd       own we  eaddr     ewd       erd
        vt[0] = '{0, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0000, 16'hBEEF};
        vt[1] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1000, 16'h1234, 1, 1, 16'h1000, 16'h1234, 16'h0F0F};
        vt[2] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h1000, 16'h0000, 1, 0, 16'h1000, 16'h0000, 16'h1234};
        vt[3] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 0, 16'h0080, 16'h0000, 16'hA5A5};
        vt[4] = '{0, 1, 0, 16'h0040, 16'h0007, 1, 1, 16'h0080, 16'h9999, 0, 0, 16'h0040, 16'h0007, 16'hBEEF};
        vt[5] = '{1, 1, 1, 16'h2000, 16'hCAFE, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h2000, 16'hCAFE, 16'h5555};
        vt[6] = '{1, 1, 0, 16'h2000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h2000, 16'h0000, 16'hCAFE};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_mem_en", mem_en[d], 0);
            chk("rst_acks", {cpu_ack[d], dma_ack[d]}, 0);
            chk("rst_rdata", {cpu_rdata[d], dma_rdata[d]}, 0);
            chk("rst_mem_bus", {mem_we[d], mem_addr[d], mem_wdata[d]}, 0);
            chk("rst_owner", owner[d], 0);
        end
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vt[i], 0);

        // CPU drops its request during WAIT; the DMA read data must survive
        run_vec(vt[0], 2);
        chk("drop_dma_rdata", dma_rdata[0], 16'hA5A5);

        // back-to-back CPU reads on the MEM_LAT=3 arbiter
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 16'h0040;
        t1 = 0; t2 = 0; en2 = 0; addr2 = '0; rd2 = '0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (mem_en[1]) begin en2++; if (en2 == 2) addr2 = mem_addr[1]; end
            if (cpu_ack[1]) begin
                if (t1 == 0) t1 = t;
                else if (t2 == 0) begin t2 = t; rd2 = cpu_rdata[1]; cpu_req[1] = 0; end
            end
            if (t1 != 0 && t == t1 + 1) cpu_addr[1] = 16'h0042;
        end
        chk("b2b_first_ack", t1, 5);
        chk("b2b_spacing", t2 - t1, 6);
        chk("b2b_en_pulses", en2, 2);
        chk("b2b_addr2", addr2, 16'h0042);
        chk("b2b_rdata2", rd2, 16'h1111);

        // reset asserted while the MEM_LAT=3 arbiter is in WAIT
        cpu_req[1] = 1; cpu_addr[1] = 16'h0040;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_before", busy[1], 1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_busy", busy[d], 0);
            chk("mid_mem_en", mem_en[d], 0);
            chk("mid_acks", {cpu_ack[d], dma_ack[d]}, 0);
            chk("mid_rdata", {cpu_rdata[d], dma_rdata[d]}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        rv = '{1, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0000, 16'hBEEF};
        run_vec(rv, 0);

        // both requesting continuously: DMA forced in after three CPU wins
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h0040;
        dma_req[0] = 1; dma_we[0] = 0; dma_addr[0] = 16'h0080;
        n = 0;
        for (int i = 0; i < 8; i++) begin ack_a[i] = -100; own_a[i] = 2; end
        for (int t = 1; t <= 60 && n < 8; t++) begin
            @(posedge clk); #1;
            if (cpu_ack[0] || dma_ack[0]) begin
                own_a[n] = dma_ack[0] ? 1 : 0; ack_a[n] = t; n++;
                if (n == 8) begin cpu_req[0] = 0; dma_req[0] = 0; end
            end
        end
        cpu_req[0] = 0; dma_req[0] = 0;
        for (int i = 0; i < 8; i++) chk("grant_order", own_a[i], (i % 4 == 3) ? 1 : 0);
        for (int i = 1; i < 8; i++) chk("grant_spacing", ack_a[i] - ack_a[i-1], 4);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
